// File: rtl/sample_collector_pkg.sv
// Shared types and constants for the sample_collector block and its PWM generator.
package sample_collector_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    MIX  = 2'd2
  } collector_state_t;

  localparam int SAMPLE_W = 8;
  localparam logic [7:0] PWM_MAX = 8'd254;

endpackage

// File: rtl/sample_collector_pwm_gen.sv
// 255-state PWM generator; duty is only taken at the 254->0 wrap so a period is never split.
module pwm_gen
  import sample_collector_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] duty,
  output logic       pwm_out
);

  logic [7:0] pwm_cnt;
  logic [7:0] duty_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= 8'd0;
      duty_q  <= 8'd0;
      pwm_out <= 1'b0;
    end else begin
      if (pwm_cnt == PWM_MAX) begin
        pwm_cnt <= 8'd0;
        duty_q  <= duty;
      end else begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
      // With 255 counter states, duty 255 keeps the compare true on every state.
      pwm_out <= (pwm_cnt < duty_q);
    end
  end

endmodule

// File: rtl/sample_collector.sv
// Voice sample initiator: frame strobe, per-voice sample collection, averaging mix and audio out.
// Define SAMPLE_COLLECTOR_PWM_EN to build the PWM output; otherwise pwm_out is tied low.
module sample_collector
  import sample_collector_pkg::*;
#(
  parameter int NUM_VOICES    = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int TIMEOUT       = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [NUM_VOICES-1:0]          voice_done,
  input  logic [SAMPLE_W*NUM_VOICES-1:0] voice_sample,
  output logic                           sample_now,
  output logic [7:0]                     mix_out,
  output logic                           mix_valid,
  output logic                           timeout_err,
  output logic                           pwm_out
);

  localparam int LG    = $clog2(NUM_VOICES);
  localparam int SUM_W = SAMPLE_W + LG;
  localparam int CW    = $clog2(SAMPLE_PERIOD);
  localparam int TW    = $clog2(TIMEOUT + 1);

  collector_state_t      state, state_nxt;
  logic [CW-1:0]         frame_cnt, frame_nxt;
  logic [TW-1:0]         tcnt;
  logic [NUM_VOICES-1:0] got, got_nxt;
  logic                  all_got, timed_out;
  logic [SAMPLE_W-1:0]   slot [NUM_VOICES];
  logic [SUM_W-1:0]      sum;

  always_comb begin
    frame_nxt = '0;
    if (en) frame_nxt = (frame_cnt == CW'(SAMPLE_PERIOD - 1)) ? '0 : frame_cnt + CW'(1);
    got_nxt   = got | voice_done;
    all_got   = &got_nxt;
    // tcnt is the pre-increment value, so this fires on the WAIT cycle that brings it to TIMEOUT-1.
    timed_out = (tcnt == TW'(TIMEOUT - 2));
    state_nxt = state;
    case (state)
      IDLE:    if (sample_now && en) state_nxt = WAIT;
      WAIT:    if (!en) state_nxt = IDLE;
               else if (all_got || timed_out) state_nxt = MIX;
      MIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) sum = sum + SUM_W'(slot[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      frame_cnt   <= '0;
      tcnt        <= '0;
      got         <= '0;
      sample_now  <= 1'b0;
      mix_out     <= 8'h00;
      mix_valid   <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) slot[i] <= '0;
    end else begin
      state      <= state_nxt;
      frame_cnt  <= frame_nxt;
      // Strobe is registered one cycle ahead; a busy FSM at the frame boundary drops the frame.
      sample_now <= en && (frame_nxt == CW'(SAMPLE_PERIOD - 1)) && (state_nxt == IDLE);
      mix_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (state_nxt == WAIT) begin
            got  <= '0;
            tcnt <= '0;
          end
        end
        WAIT: begin
          got  <= got_nxt;
          tcnt <= tcnt + TW'(1);
          for (int i = 0; i < NUM_VOICES; i++)
            if (voice_done[i]) slot[i] <= voice_sample[SAMPLE_W*i +: SAMPLE_W];
          if (state_nxt == MIX) timeout_err <= !all_got;
        end
        MIX: begin
          if (en) begin
            mix_out   <= 8'(sum >> LG);
            mix_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SAMPLE_COLLECTOR_PWM_EN
  pwm_gen u_pwm_gen (
    .clk     (clk),
    .rst     (rst),
    .duty    (mix_out),
    .pwm_out (pwm_out)
  );
`else
  assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_sample_collector.sv
// Bench for sample_collector; build with +define+SAMPLE_COLLECTOR_PWM_EN to cover the PWM output.
module tb_sample_collector;

  localparam int NV = 4;
  localparam int SP = 100;
  localparam int TO = 64;

  typedef logic [7:0] smp_t [NV];
  typedef int         dly_t [NV];
  typedef bit         pres_t [NV];

  logic            clk = 1'b0;
  logic            rst, en;
  logic [NV-1:0]   voice_done;
  logic [8*NV-1:0] voice_sample;
  logic            sample_now, mix_valid, timeout_err, pwm_out;
  logic [7:0]      mix_out;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int last_strobe = -1;
  logic [7:0] exp_q[$];
  int mdl_slot [NV];

  always #5 clk = ~clk;

  sample_collector #(
    .NUM_VOICES    (NV),
    .SAMPLE_PERIOD (SP),
    .TIMEOUT       (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .voice_done   (voice_done),
    .voice_sample (voice_sample),
    .sample_now   (sample_now),
    .mix_out      (mix_out),
    .mix_valid    (mix_valid),
    .timeout_err  (timeout_err),
    .pwm_out      (pwm_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
`ifndef SAMPLE_COLLECTOR_PWM_EN
    chk("pwm_tied_low", pwm_out, 0);
`endif
  endtask

  task automatic check_reset_outputs();
    chk("rst_sample_now", sample_now, 0);
    chk("rst_mix_out", mix_out, 0);
    chk("rst_mix_valid", mix_valid, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_pwm_out", pwm_out, 0);
  endtask

  // Current cycle is enabled cycle 1 with the frame counter at zero.
  task automatic first_strobe();
    int n = 1;
    while (sample_now !== 1'b1 && n < 3*SP) begin
      tick();
      n++;
    end
    chk("first_strobe_cycle", n, SP);
    last_strobe = cyc;
  endtask

  task automatic next_strobe();
    int n = 0;
    do begin
      tick();
      n++;
    end while (sample_now !== 1'b1 && n < 3*SP);
    chk("strobe_seen", sample_now, 1);
    if (last_strobe >= 0) chk("strobe_period", cyc - last_strobe, SP);
    last_strobe = cyc;
  endtask

  // Called in the strobe cycle; drives the voices and checks the resulting mix.
  task automatic frame(input smp_t smp, input dly_t dly, input pres_t pres);
    bit full = 1'b1;
    int maxd = 0;
    int total = 0;
    int ev;
    bit exp_err;
    logic [7:0] e;
    for (int i = 0; i < NV; i++) begin
      if (pres[i]) begin
        mdl_slot[i] = smp[i];
        if (dly[i] > maxd) maxd = dly[i];
      end else full = 1'b0;
    end
    for (int i = 0; i < NV; i++) total += mdl_slot[i];
    exp_q.push_back(8'(total / NV));
    exp_err = !full;
    ev = full ? maxd + 2 : TO + 1;
    for (int k = 1; k <= ev; k++) begin
      tick();
      voice_done   = '0;
      voice_sample = $urandom;
      for (int i = 0; i < NV; i++)
        if (pres[i] && dly[i] == k) begin
          voice_done[i] = 1'b1;
          voice_sample[8*i +: 8] = smp[i];
        end
      if (k == 1) chk("strobe_width", sample_now, 0);
      if (k < ev) chk("early_mix_valid", mix_valid, 0);
      else begin
        chk("mix_valid", mix_valid, 1);
        e = exp_q.pop_front();
        chk("mix_out", mix_out, e);
        chk("timeout_err", timeout_err, exp_err);
      end
    end
    voice_done = '0;
  endtask

`ifdef SAMPLE_COLLECTOR_PWM_EN
  task automatic pwm_window(input int duty);
    int hi = 0;
    repeat (300) tick();
    repeat (255) begin
      tick();
      hi += int'(pwm_out);
    end
    chk("pwm_high_cycles", hi, duty);
  endtask
`endif

  initial begin
    smp_t  s;
    dly_t  d;
    pres_t p;
    logic [7:0] v;
    logic [7:0] levels [3];

    rst = 1'b1; en = 1'b0; voice_done = '0; voice_sample = '0;
    for (int i = 0; i < NV; i++) mdl_slot[i] = 0;
    tick();
    tick();
    check_reset_outputs();

    rst = 1'b0; en = 1'b1;
    first_strobe();
    s = '{8'h00, 8'h00, 8'h00, 8'h00}; d = '{1, 1, 1, 1}; p = '{0, 0, 0, 0};
    frame(s, d, p);

    next_strobe();
    s = '{8'h10, 8'h20, 8'h30, 8'h40}; d = '{5, 9, 12, 20}; p = '{1, 1, 1, 1};
    frame(s, d, p);

    next_strobe();
    s = '{8'h80, 8'h80, 8'h80, 8'h00}; d = '{3, 7, 11, 1}; p = '{1, 1, 1, 0};
    frame(s, d, p);

    next_strobe();
    for (int i = 0; i < NV; i++) begin
      s[i] = 8'($urandom); d[i] = $urandom_range(1, 40); p[i] = 1'b1;
    end
    frame(s, d, p);

    for (int f = 0; f < 6; f++) begin
      next_strobe();
      for (int i = 0; i < NV; i++) begin
        s[i] = 8'($urandom); d[i] = $urandom_range(1, 40); p[i] = ($urandom_range(0, 3) != 0);
      end
      frame(s, d, p);
    end

    next_strobe();
    for (int i = 0; i < NV; i++) begin
      s[i] = 8'($urandom); d[i] = 1; p[i] = 1'b1;
    end
    frame(s, d, p);

    levels[0] = 8'hFF; levels[1] = 8'h00; levels[2] = 8'h80;
    for (int l = 0; l < 3; l++) begin
      next_strobe();
      v = levels[l];
      for (int i = 0; i < NV; i++) begin
        s[i] = v; d[i] = $urandom_range(1, 30); p[i] = 1'b1;
      end
      frame(s, d, p);
`ifdef SAMPLE_COLLECTOR_PWM_EN
      pwm_window(int'(v));
      last_strobe = -1;
`endif
    end

    // enable dropped mid-collection
    next_strobe();
    tick();
    tick();
    tick();
    voice_done = 4'b0011;
    voice_sample = $urandom;
    voice_sample[7:0] = 8'h5A; voice_sample[15:8] = 8'hC3;
    mdl_slot[0] = 8'h5A; mdl_slot[1] = 8'hC3;
    tick();
    voice_done = '0;
    tick();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("en_drop_mix_valid", mix_valid, 0);
      chk("en_drop_sample_now", sample_now, 0);
    end
    en = 1'b1;
    last_strobe = -1;
    first_strobe();
    s = '{8'h00, 8'h00, 8'h00, 8'h00}; d = '{1, 1, 1, 1}; p = '{0, 0, 0, 0};
    frame(s, d, p);

    // reset mid-collection
    next_strobe();
    tick();
    tick();
    voice_done = 4'b0001;
    voice_sample = $urandom;
    tick();
    voice_done = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NV; i++) mdl_slot[i] = 0;
    check_reset_outputs();
    last_strobe = -1;
    first_strobe();
    frame(s, d, p);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
